// File: rtl/bf_tape_mem.sv
// Byte-wide tape memory with configurable read latency and write occupancy, plus a sequential clear.
// Define BF_TAPE_MEM_CHECK_EN to build the sticky protocol-violation checker behind proto_err.
module bf_tape_mem #(
    parameter int logsize = 7,
    parameter int rd_lat  = 2,
    parameter int wr_lat  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_init,
    input  logic [logsize-1:0] mem_addr,
    input  logic [7:0]         mem_wdata,
    input  logic               mem_wselect,
    input  logic               mem_doit,
    output logic               mem_busy,
    output logic               mem_rvalid,
    output logic [7:0]         mem_rdata,
    output logic               proto_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    localparam int         DEPTH  = 1 << logsize;
    localparam logic [3:0] RD_CNT = 4'(rd_lat - 1);
    localparam logic [3:0] WR_CNT = 4'(wr_lat - 1);

    logic [1:0]         state;
    logic [3:0]         lat_cnt;
    logic [logsize-1:0] addr_q;
    logic [7:0]         wdata_q;
    logic [logsize-1:0] clr_cnt;

    logic [7:0]         mem [DEPTH];

    logic               mem_we;
    logic [logsize-1:0] mem_waddr;
    logic [7:0]         mem_wval;

    // Single write port shared by the clear sweep and the pending write; init aborts the write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wval  = wdata_q;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wval  = 8'h00;
        end else if (state == WRITE && lat_cnt == 4'd0 && !mem_init) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the array has no reset; the initiator clears it with mem_init before use.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wval;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            clr_cnt    <= '0;
            mem_busy   <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= 8'h00;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_init) begin
                state    <= CLEAR;
                clr_cnt  <= '0;
                mem_busy <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (mem_doit) begin
                            addr_q   <= mem_addr;
                            wdata_q  <= mem_wdata;
                            mem_busy <= 1'b1;
                            if (mem_wselect) begin
                                state   <= WRITE;
                                lat_cnt <= WR_CNT;
                            end else begin
                                state   <= READ;
                                lat_cnt <= RD_CNT;
                                if (rd_lat == 1) begin
                                    mem_rvalid <= 1'b1;
                                    mem_rdata  <= mem[mem_addr];
                                end
                            end
                        end
                    end
                    READ: begin
                        // rvalid is raised one edge before the counter expires so it lands in the last busy cycle.
                        if (lat_cnt == 4'd0) begin
                            state    <= IDLE;
                            mem_busy <= 1'b0;
                        end else begin
                            lat_cnt <= lat_cnt - 4'd1;
                            if (lat_cnt == 4'd1) begin
                                mem_rvalid <= 1'b1;
                                mem_rdata  <= mem[addr_q];
                            end
                        end
                    end
                    WRITE: begin
                        if (lat_cnt == 4'd0) begin
                            state    <= IDLE;
                            mem_busy <= 1'b0;
                        end else begin
                            lat_cnt <= lat_cnt - 4'd1;
                        end
                    end
                    CLEAR: begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == '1) begin
                            state    <= IDLE;
                            mem_busy <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

`ifdef BF_TAPE_MEM_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (mem_doit && (mem_busy || mem_init)) begin
            proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule
